rgb_button_ctrl: RTL and testbench
==================================

Name: rgb_button_ctrl

Overview:
Parametrised button-to-RGB LED controller.
- Takes N_BTN raw, asynchronous push buttons.
- Synchronises and debounces each button, then picks a winner by fixed priority.
- Looks up the winner's colour in a runtime colour table.
- Drives the three LED pins through a shared PWM brightness stage.
- Supports momentary mode (LED follows the held button) and latched mode (press selects, press again releases).

Parameters:
N_BTN, 4, number of button inputs (1..16).
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button change (>=1).
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
PWM_W, 8, PWM counter and duty width.
IDX_W, 2, width of active_idx; equals clog2(N_BTN), minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset
btn  in  N_BTN  raw buttons, active-high, asynchronous
mode_latch  in  1  0 = momentary, 1 = latched
color_map  in  3*N_BTN  colour per button; entry i = color_map[3i+2:3i] = {R,G,B}
duty  in  PWM_W  brightness duty
led_red  out  1  red drive, registered
led_green  out  1  green drive, registered
led_blue  out  1  blue drive, registered
sel_valid  out  1  a colour is currently selected
active_idx  out  IDX_W  index of the selected button; 0 when sel_valid=0

Behaviour:
- Reset: rst is synchronous, active-high. It clears all synchroniser flops, debounced states, debounce counters, latched selection, PWM counter, all LED outputs, sel_valid and active_idx to 0.
- Synchroniser: each btn[i] passes through a 2-flop synchroniser to give s[i].
- Debounce, per button:
  - Counter increments while s[i] != db[i].
  - Counter clears to 0 on any cycle where s[i] == db[i].
  - db[i] flips, and the counter clears, on the edge where the counter equals DEBOUNCE_CYCLES-1 and s[i] still differs.
  - Result: a change must persist DEBOUNCE_CYCLES consecutive cycles; glitches shorter than that never propagate.
- Priority: among asserted db bits, the lowest index wins.
- Momentary mode (mode_latch=0):
  - Selection is the highest-priority asserted db bit.
  - No asserted bit gives sel_valid=0.
  - Recomputed every cycle.
- Latched mode (mode_latch=1):
  - rise = db & ~db_prev, where db_prev is db registered by one cycle.
  - Selection changes only when rise != 0. The winner is the lowest-index bit of rise.
  - If the winner equals the current active_idx while sel_valid=1, selection clears (toggle off). Otherwise the winner is selected.
  - Releasing a button has no effect.
- Mode change: any cycle where mode_latch differs from its registered copy clears the latched selection. The new mode takes effect the following cycle.
- PWM:
  - pwm_cnt is free-running and wraps from 2^PWM_W-1 to 0.
  - pwm_on = (pwm_cnt < duty).
  - duty = 2^PWM_W-1 forces pwm_on=1 permanently.
  - duty = 0 gives outputs always 0.
- Output stage, registered:
  - led_red = c[2] & sel_valid & pwm_on, where c is the colour entry of active_idx.
  - led_green = c[1] & sel_valid & pwm_on.
  - led_blue = c[0] & sel_valid & pwm_on.
  - sel_valid and active_idx are registered alongside the LED outputs.
- color_map changes take effect on the next output register update, with no hold or capture.
- Latency from a btn edge to the LED outputs is 2 (sync) + DEBOUNCE_CYCLES + 1 (select) + 1 (output) cycles.

Optional Feature:
RGB_BLINK_EN
- Defined:
  - Adds input port blink (1 bit) and parameter BLINK_DIV (default 1000000).
  - A blink phase flop toggles every BLINK_DIV cycles; its divider and phase reset to 0.
  - While blink=1, the LED outputs are additionally ANDed with the blink phase.
  - sel_valid and active_idx are unaffected.
  - blink=0 holds the divider at 0 and the phase at 1.
- Undefined:
  - No blink port, divider or phase logic.
  - Outputs exactly as specified above.

Test Plan:
All scenarios use N_BTN=4, DEBOUNCE_CYCLES=4, PWM_W=4, duty=15 and color_map entries {0:100, 1:010, 2:001, 3:110}.
1. Reset and debounce: rst for 2 cycles gives all outputs 0. btn[1] high for 3 cycles then low gives no change. btn[1] held gives led_green=1 and active_idx=1 exactly 8 cycles after the btn edge.
2. Momentary priority: hold btn[3], then btn[0] → outputs 110 then 100. Release btn[0] → 110. Release all → 000, sel_valid=0.
3. Latched toggle: mode_latch=1. Press/release btn[2] → 001 held after release. Press btn[2] again → 000, sel_valid=0. btn[1] and btn[3] rising on the same cycle → select index 1, output 010.
4. PWM: latched selection 100, duty=4 → led_red high 4 of every 16 cycles. duty=0 → never high. duty=15 → constant high.
5. Mode switch and reset mid-operation: latched 010, toggle mode_latch 1→0 with no buttons → 000 next cycle. rst asserted while a debounce counter is at 2 → after reset the button needs 4 fresh stable cycles.
6. With RGB_BLINK_EN, BLINK_DIV=8, blink=1, selection 110 → red and green toggle together every 8 cycles while sel_valid stays 1.

Source files
------------

// File: rtl/rgb_button_ctrl.sv
// rgb_button_ctrl: button-to-RGB LED controller.
//
// Each raw button is synchronised by two flops and debounced. The debounced buttons
// pick a winner by fixed priority, where the lowest index wins. The winner's colour
// is looked up in a runtime colour table. The three LED pins are then gated by a
// shared PWM brightness stage.
//
// Two selection modes:
//   - Momentary (mode_latch=0): the LED follows the held button.
//   - Latched (mode_latch=1): a press selects a button, and a second press of the
//     same button releases it.
//
// Pipeline from a btn edge to the LED pins:
//   2 sync + DEBOUNCE_CYCLES debounce + 1 select + 1 output register.
//
// Build option:
//   RGB_BLINK_EN -- adds the blink input and the BLINK_DIV parameter. While blink=1,
//                   the LED pins are additionally gated by a phase that toggles every
//                   BLINK_DIV cycles.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   btn         raw asynchronous buttons, active-high
//   mode_latch  0 = momentary, 1 = latched
//   color_map   per-button colour; entry i = color_map[3i+2:3i] = {R,G,B}
//   duty        PWM brightness duty (all ones = always on)
//   led_red     registered red drive
//   led_green   registered green drive
//   led_blue    registered blue drive
//   sel_valid   registered: a colour is selected
//   active_idx  registered: index of the selected button, 0 when sel_valid=0
//   blink       (RGB_BLINK_EN only) enable blinking of the LED pins
module rgb_button_ctrl #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned PWM_W           = 8,
  parameter int unsigned IDX_W           = 2
`ifdef RGB_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV       = 1000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   btn,
  input  logic               mode_latch,
  input  logic [3*N_BTN-1:0] color_map,
  input  logic [PWM_W-1:0]   duty,
`ifdef RGB_BLINK_EN
  input  logic               blink,
`endif
  output logic               led_red,
  output logic               led_green,
  output logic               led_blue,
  output logic               sel_valid,
  output logic [IDX_W-1:0]   active_idx
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // The counter runs only while the synchronised input disagrees with the
  // debounced state. Any agreeing cycle restarts the count, so a glitch shorter
  // than DEBOUNCE_CYCLES never reaches db_q.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] db_q, db_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority encoders: the lowest set index wins, and the result is 0 when no bit
  // is set.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] db_prev_q;
  logic [N_BTN-1:0] rise;
  logic             db_any, rise_any;
  logic [IDX_W-1:0] db_win, rise_win;

  assign rise     = db_q & ~db_prev_q;
  assign db_any   = |db_q;
  assign rise_any = |rise;

  always_comb begin
    db_win   = '0;
    rise_win = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (db_q[i]) begin
        db_win = IDX_W'(i);
      end
      if (rise[i]) begin
        rise_win = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selection
  // mode_q is the mode in effect this cycle. A cycle where mode_latch disagrees
  // with mode_q clears the selection, and the new mode applies from the next cycle.
  // ---------------------------------------------------------------------------
  logic             mode_q;
  logic             sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;

  always_comb begin
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    if (mode_latch != mode_q) begin
      sel_valid_d = 1'b0;
      sel_idx_d   = '0;
    end else if (!mode_q) begin
      sel_valid_d = db_any;
      sel_idx_d   = db_win;
    end else if (rise_any) begin
      if (sel_valid_q && (rise_win == sel_idx_q)) begin
        // Pressing the active button again releases it.
        sel_valid_d = 1'b0;
        sel_idx_d   = '0;
      end else begin
        sel_valid_d = 1'b1;
        sel_idx_d   = rise_win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_prev_q   <= '0;
      mode_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
    end else begin
      db_prev_q   <= db_q;
      mode_q      <= mode_latch;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             pwm_on;

  // Full-scale duty is forced on; otherwise the compare would drop the top count.
  assign pwm_on = (pwm_cnt_q < duty) | (&duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink gate
  // ---------------------------------------------------------------------------
  logic blink_gate;

`ifdef RGB_BLINK_EN
  logic [31:0] blink_div_q, blink_div_d;
  logic        blink_phase_q, blink_phase_d;

  always_comb begin
    blink_div_d   = blink_div_q;
    blink_phase_d = blink_phase_q;
    if (!blink) begin
      blink_div_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_div_q == 32'(BLINK_DIV - 1)) begin
      blink_div_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_div_d   = blink_div_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_div_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_div_q   <= blink_div_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_gate = ~blink | blink_phase_q;
`else
  assign blink_gate = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Colour lookup and output register
  // color_map is read live, so a table change shows at the next output update.
  // ---------------------------------------------------------------------------
  logic [2:0] color;
  logic       led_en;
  logic       led_red_d, led_green_d, led_blue_d;

  always_comb begin
    color = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        color = color_map[3*i +: 3];
      end
    end
  end

  assign led_en      = sel_valid_q & pwm_on & blink_gate;
  assign led_red_d   = color[2] & led_en;
  assign led_green_d = color[1] & led_en;
  assign led_blue_d  = color[0] & led_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_red    <= 1'b0;
      led_green  <= 1'b0;
      led_blue   <= 1'b0;
      sel_valid  <= 1'b0;
      active_idx <= '0;
    end else begin
      led_red    <= led_red_d;
      led_green  <= led_green_d;
      led_blue   <= led_blue_d;
      sel_valid  <= sel_valid_q;
      active_idx <= sel_idx_q;
    end
  end

endmodule

// File: tb/tb_rgb_button_ctrl.sv
// Testbench for rgb_button_ctrl.
//
// Expected output vectors {R,G,B,sel_valid,active_idx} are queued with a due cycle
// when stimulus is driven. A negedge monitor pops each one and compares it when its
// cycle arrives.
module tb_rgb_button_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic        mode_latch;
  logic [11:0] color_map;
  logic [3:0]  duty;
  logic        led_red, led_green, led_blue, sel_valid;
  logic [1:0]  active_idx;
`ifdef RGB_BLINK_EN
  logic        blink;
`endif

  always #5 clk = ~clk;

`ifdef RGB_BLINK_EN
  rgb_button_ctrl #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .PWM_W(4), .IDX_W(2), .BLINK_DIV(8)
  ) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .mode_latch(mode_latch), .color_map(color_map),
    .duty(duty), .blink(blink), .led_red(led_red), .led_green(led_green),
    .led_blue(led_blue), .sel_valid(sel_valid), .active_idx(active_idx)
  );
`else
  rgb_button_ctrl #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .PWM_W(4), .IDX_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .mode_latch(mode_latch), .color_map(color_map),
    .duty(duty), .led_red(led_red), .led_green(led_green),
    .led_blue(led_blue), .sel_valid(sel_valid), .active_idx(active_idx)
  );
`endif

  logic [5:0] obs;
  assign obs = {led_red, led_green, led_blue, sel_valid, active_idx};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference table: {0:100, 1:010, 2:001, 3:110}.
  function automatic logic [5:0] exp_vec(input int idx);
    logic [2:0] c;
    case (idx)
      0:       c = 3'b100;
      1:       c = 3'b010;
      2:       c = 3'b001;
      default: c = 3'b110;
    endcase
    return {c, 1'b1, 2'(idx)};
  endfunction

  // Scoreboard
  int         due_q[$];
  logic [5:0] exp_q[$];
  string      tag_q[$];

  task automatic expect_at(input int d, input logic [5:0] v, input string tag);
    due_q.push_back(cyc + d);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    for (int k = due_q.size() - 1; k >= 0; k--) begin
      if (due_q[k] == cyc) begin
        check(tag_q[k], {26'd0, obs}, {26'd0, exp_q[k]});
        due_q.delete(k);
        exp_q.delete(k);
        tag_q.delete(k);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (due_q.size() > 0 && guard < 200) begin
      tick(1);
      guard++;
    end
    if (due_q.size() > 0) begin
      check("sb_timeout", due_q.size(), 0);
      due_q.delete();
      exp_q.delete();
      tag_q.delete();
    end
    tick(1);
  endtask

  task automatic count_red(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(led_red);
    end
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst        = 1'b1;
    btn        = 4'b0000;
    mode_latch = 1'b0;
    color_map  = 12'b110_001_010_100;
    duty       = 4'd15;
`ifdef RGB_BLINK_EN
    blink      = 1'b0;
`endif

    // 1. Reset and debounce
    tick(1);
    check("rst_c1", {26'd0, obs}, 32'd0);
    tick(1);
    check("rst_c2", {26'd0, obs}, 32'd0);
    rst = 1'b0;
    tick(2);

    btn = 4'b0010;
    for (int d = 1; d <= 12; d++) expect_at(d, 6'd0, "glitch");
    tick(3);
    btn = 4'b0000;
    drain();

    btn = 4'b0010;
    expect_at(7, 6'd0, "deb_lat7");
    expect_at(8, exp_vec(1), "deb_lat8");
    drain();

    // 2. Momentary priority
    btn = 4'b1000;
    expect_at(7, exp_vec(1), "mom_b3_pre");
    expect_at(8, exp_vec(3), "mom_b3");
    drain();
    btn = 4'b1001;
    expect_at(8, exp_vec(0), "mom_b0_wins");
    drain();
    btn = 4'b1000;
    expect_at(8, exp_vec(3), "mom_rel_b0");
    drain();
    btn = 4'b0000;
    expect_at(8, 6'd0, "mom_rel_all");
    drain();

    // 3. Latched toggle
    mode_latch = 1'b1;
    tick(2);
    btn = 4'b0100;
    expect_at(8, exp_vec(2), "lat_sel2");
    drain();
    btn = 4'b0000;
    expect_at(12, exp_vec(2), "lat_hold2");
    drain();
    btn = 4'b0100;
    expect_at(8, 6'd0, "lat_toggle_off");
    drain();
    btn = 4'b0000;
    expect_at(12, 6'd0, "lat_off_hold");
    drain();
    btn = 4'b1010;
    expect_at(8, exp_vec(1), "lat_prio13");
    drain();
    btn = 4'b0000;
    expect_at(12, exp_vec(1), "lat_hold1");
    drain();

    // 4. PWM on latched red
    btn = 4'b0001;
    expect_at(8, exp_vec(0), "pwm_sel0");
    drain();
    btn = 4'b0000;
    expect_at(12, exp_vec(0), "pwm_hold0");
    drain();
    duty = 4'd4;
    tick(2);
    count_red(32, cnt);
    check("pwm_duty4", cnt, 8);
    duty = 4'd0;
    tick(2);
    count_red(32, cnt);
    check("pwm_duty0", cnt, 0);
    duty = 4'd15;
    tick(2);
    count_red(32, cnt);
    check("pwm_duty15", cnt, 32);

    // 5. Mode switch, then reset mid-debounce
    btn = 4'b0010;
    expect_at(8, exp_vec(1), "msw_sel1");
    drain();
    btn = 4'b0000;
    expect_at(12, exp_vec(1), "msw_hold1");
    drain();
    mode_latch = 1'b0;
    expect_at(1, exp_vec(1), "msw_c1");
    expect_at(2, 6'd0, "msw_c2");
    expect_at(6, 6'd0, "msw_c6");
    drain();

    btn = 4'b1000;
    expect_at(8, exp_vec(3), "rstm_pre");
    drain();
    btn = 4'b1001;
    tick(4);
    rst = 1'b1;
    expect_at(1, 6'd0, "rstm_clear");
    tick(1);
    rst = 1'b0;
    expect_at(7, 6'd0, "rstm_fresh7");
    expect_at(8, exp_vec(0), "rstm_fresh8");
    drain();

`ifdef RGB_BLINK_EN
    // 6. Blink on 110
    btn = 4'b1000;
    expect_at(8, exp_vec(3), "blk_sel3");
    drain();
    blink = 1'b1;
    tick(2);
    begin
      int red_n   = 0;
      int diff_n  = 0;
      int valid_n = 0;
      repeat (32) begin
        @(negedge clk);
        red_n   += int'(led_red);
        diff_n  += int'(led_red != led_green);
        valid_n += int'(sel_valid);
      end
      check("blk_red_half", red_n, 16);
      check("blk_rg_same", diff_n, 0);
      check("blk_valid", valid_n, 32);
    end
    tick(1);
    blink = 1'b0;
`endif

    btn = 4'b0000;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
